// File: rtl/z80fi_insn_capture.sv
// Purpose : assemble per-cycle core trace events into one retired-instruction packet.
// Latency : z80fi_valid pulses one cycle after the ev_retire cycle.
// Backpr. : none; events beyond packet capacity are dropped and flagged via z80fi_overflow.
//
// Ports: clk/reset_n (async active-low); ev_* trace events from the core;
// z80fi_* packet bus, qualified by the single-cycle z80fi_valid strobe.
module z80fi_insn_capture #(
    parameter int MAX_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ev_start,
    input  logic [15:0]            ev_pc,
    input  logic                   ev_fetch,
    input  logic [7:0]             ev_fetch_byte,
    input  logic                   ev_reg_rd,
    input  logic [3:0]             ev_reg_rnum,
    input  logic [15:0]            ev_reg_rdata,
    input  logic                   ev_mem_rd,
    input  logic [15:0]            ev_mem_addr,
    input  logic [7:0]             ev_mem_data,
    input  logic                   ev_mem_wr,
    input  logic                   ev_reg_wr,
    input  logic [3:0]             ev_reg_wnum,
    input  logic [15:0]            ev_reg_wdata,
    input  logic                   ev_retire,
    input  logic [15:0]            ev_pc_wdata,
    output logic                   z80fi_valid,
    output logic [8*MAX_LEN-1:0]   z80fi_insn,
    output logic [2:0]             z80fi_insn_len,
    output logic [15:0]            z80fi_pc_rdata,
    output logic [15:0]            z80fi_pc_wdata,
    output logic                   z80fi_reg1_rd,
    output logic [3:0]             z80fi_reg1_rnum,
    output logic [15:0]            z80fi_reg1_rdata,
    output logic                   z80fi_reg2_rd,
    output logic [3:0]             z80fi_reg2_rnum,
    output logic [15:0]            z80fi_reg2_rdata,
    output logic                   z80fi_mem_rd,
    output logic                   z80fi_mem_rd2,
    output logic                   z80fi_mem_wr,
    output logic [15:0]            z80fi_mem_addr,
    output logic [7:0]             z80fi_mem_rdata,
    output logic [7:0]             z80fi_mem_wdata,
    output logic [15:0]            z80fi_mem_addr2,
    output logic [7:0]             z80fi_mem_rdata2,
    output logic                   z80fi_reg_wr,
    output logic [3:0]             z80fi_reg_wnum,
    output logic [15:0]            z80fi_reg_wdata,
    output logic                   z80fi_overflow
);

    localparam logic [2:0] MAX_LEN_L = 3'(MAX_LEN);

    typedef struct packed {
        logic [8*MAX_LEN-1:0] insn;
        logic [2:0]           len;
        logic [15:0]          pc_rdata;
        logic [15:0]          pc_wdata;
        logic                 reg1_rd;
        logic [3:0]           reg1_rnum;
        logic [15:0]          reg1_rdata;
        logic                 reg2_rd;
        logic [3:0]           reg2_rnum;
        logic [15:0]          reg2_rdata;
        logic                 mem_rd;
        logic                 mem_rd2;
        logic                 mem_wr;
        logic [15:0]          mem_addr;
        logic [7:0]           mem_rdata;
        logic [7:0]           mem_wdata;
        logic [15:0]          mem_addr2;
        logic [7:0]           mem_rdata2;
        logic                 reg_wr;
        logic [3:0]           reg_wnum;
        logic [15:0]          reg_wdata;
        logic                 overflow;
    } pkt_t;

    typedef enum logic {S_IDLE, S_COLLECT} state_t;

    state_t state_q;
    pkt_t   acc_q;     // packet under collection
    pkt_t   out_q;     // last emitted packet
    logic   valid_q;

    pkt_t   acc_d;     // accumulator after this cycle's events
    pkt_t   ret_d;     // packet emitted if this cycle retires
    logic   emit_d;

    always_comb begin
        acc_d = acc_q;
        // A start opens a fresh packet; starting over an unretired one loses it.
        if (ev_start) begin
            acc_d          = '0;
            acc_d.pc_rdata = ev_pc;
            acc_d.overflow = (state_q == S_COLLECT) && !ev_retire;
        end

        if (ev_fetch) begin
            if (acc_d.len < MAX_LEN_L) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (acc_d.len == 3'(k)) acc_d.insn[8*k +: 8] = ev_fetch_byte;
                end
                acc_d.len = acc_d.len + 3'd1;
            end else begin
                acc_d.overflow = 1'b1;
            end
        end

        if (ev_reg_rd) begin
            if (!acc_d.reg1_rd) begin
                acc_d.reg1_rd    = 1'b1;
                acc_d.reg1_rnum  = ev_reg_rnum;
                acc_d.reg1_rdata = ev_reg_rdata;
            end else if (!acc_d.reg2_rd) begin
                acc_d.reg2_rd    = 1'b1;
                acc_d.reg2_rnum  = ev_reg_rnum;
                acc_d.reg2_rdata = ev_reg_rdata;
            end else begin
                acc_d.overflow = 1'b1;
            end
        end

        if (ev_mem_rd) begin
            if (!acc_d.mem_rd) begin
                // First read shares the address slot with a write.
                if (acc_d.mem_wr) acc_d.overflow = 1'b1;
                acc_d.mem_rd    = 1'b1;
                acc_d.mem_addr  = ev_mem_addr;
                acc_d.mem_rdata = ev_mem_data;
            end else if (!acc_d.mem_rd2) begin
                acc_d.mem_rd2    = 1'b1;
                acc_d.mem_addr2  = ev_mem_addr;
                acc_d.mem_rdata2 = ev_mem_data;
            end else begin
                acc_d.overflow = 1'b1;
            end
        end

        if (ev_mem_wr) begin
            if (acc_d.mem_wr || acc_d.mem_rd) acc_d.overflow = 1'b1;
            acc_d.mem_wr    = 1'b1;
            acc_d.mem_addr  = ev_mem_addr;
            acc_d.mem_wdata = ev_mem_data;
        end

        if (ev_reg_wr) begin
            acc_d.reg_wr    = 1'b1;
            acc_d.reg_wnum  = ev_reg_wnum;
            acc_d.reg_wdata = ev_reg_wdata;
        end

        // With a simultaneous start, this cycle's events went to the new
        // packet, so the retiring one leaves exactly as accumulated.
        ret_d          = ev_start ? acc_q : acc_d;
        ret_d.pc_wdata = ev_pc_wdata;
        if (ret_d.len == 3'd0) ret_d.overflow = 1'b1;

        emit_d = (state_q == S_COLLECT) && ev_retire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= emit_d;
            if (emit_d) out_q <= ret_d;
            case (state_q)
                S_IDLE: begin
                    if (ev_start) begin
                        state_q <= S_COLLECT;
                        acc_q   <= acc_d;
                    end
                end
                S_COLLECT: begin
                    if (ev_start) begin
                        acc_q <= acc_d;
                    end else if (ev_retire) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign z80fi_valid      = valid_q;
    assign z80fi_insn       = out_q.insn;
    assign z80fi_insn_len   = out_q.len;
    assign z80fi_pc_rdata   = out_q.pc_rdata;
    assign z80fi_pc_wdata   = out_q.pc_wdata;
    assign z80fi_reg1_rd    = out_q.reg1_rd;
    assign z80fi_reg1_rnum  = out_q.reg1_rnum;
    assign z80fi_reg1_rdata = out_q.reg1_rdata;
    assign z80fi_reg2_rd    = out_q.reg2_rd;
    assign z80fi_reg2_rnum  = out_q.reg2_rnum;
    assign z80fi_reg2_rdata = out_q.reg2_rdata;
    assign z80fi_mem_rd     = out_q.mem_rd;
    assign z80fi_mem_rd2    = out_q.mem_rd2;
    assign z80fi_mem_wr     = out_q.mem_wr;
    assign z80fi_mem_addr   = out_q.mem_addr;
    assign z80fi_mem_rdata  = out_q.mem_rdata;
    assign z80fi_mem_wdata  = out_q.mem_wdata;
    assign z80fi_mem_addr2  = out_q.mem_addr2;
    assign z80fi_mem_rdata2 = out_q.mem_rdata2;
    assign z80fi_reg_wr     = out_q.reg_wr;
    assign z80fi_reg_wnum   = out_q.reg_wnum;
    assign z80fi_reg_wdata  = out_q.reg_wdata;
    assign z80fi_overflow   = out_q.overflow;

endmodule

// File: tb/tb_z80fi_insn_capture.sv
module tb_z80fi_insn_capture;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ev_start, ev_fetch, ev_reg_rd, ev_mem_rd, ev_mem_wr, ev_reg_wr, ev_retire;
    logic [15:0] ev_pc, ev_reg_rdata, ev_mem_addr, ev_reg_wdata, ev_pc_wdata;
    logic [7:0]  ev_fetch_byte, ev_mem_data;
    logic [3:0]  ev_reg_rnum, ev_reg_wnum;

    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata, z80fi_pc_wdata;
    logic        z80fi_reg1_rd, z80fi_reg2_rd;
    logic [3:0]  z80fi_reg1_rnum, z80fi_reg2_rnum;
    logic [15:0] z80fi_reg1_rdata, z80fi_reg2_rdata;
    logic        z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr;
    logic [15:0] z80fi_mem_addr, z80fi_mem_addr2;
    logic [7:0]  z80fi_mem_rdata, z80fi_mem_wdata, z80fi_mem_rdata2;
    logic        z80fi_reg_wr;
    logic [3:0]  z80fi_reg_wnum;
    logic [15:0] z80fi_reg_wdata;
    logic        z80fi_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z80fi_insn_capture #(.MAX_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .ev_start(ev_start), .ev_pc(ev_pc),
        .ev_fetch(ev_fetch), .ev_fetch_byte(ev_fetch_byte),
        .ev_reg_rd(ev_reg_rd), .ev_reg_rnum(ev_reg_rnum), .ev_reg_rdata(ev_reg_rdata),
        .ev_mem_rd(ev_mem_rd), .ev_mem_addr(ev_mem_addr), .ev_mem_data(ev_mem_data),
        .ev_mem_wr(ev_mem_wr),
        .ev_reg_wr(ev_reg_wr), .ev_reg_wnum(ev_reg_wnum), .ev_reg_wdata(ev_reg_wdata),
        .ev_retire(ev_retire), .ev_pc_wdata(ev_pc_wdata),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_pc_wdata(z80fi_pc_wdata),
        .z80fi_reg1_rd(z80fi_reg1_rd), .z80fi_reg1_rnum(z80fi_reg1_rnum), .z80fi_reg1_rdata(z80fi_reg1_rdata),
        .z80fi_reg2_rd(z80fi_reg2_rd), .z80fi_reg2_rnum(z80fi_reg2_rnum), .z80fi_reg2_rdata(z80fi_reg2_rdata),
        .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_rd2(z80fi_mem_rd2), .z80fi_mem_wr(z80fi_mem_wr),
        .z80fi_mem_addr(z80fi_mem_addr), .z80fi_mem_rdata(z80fi_mem_rdata), .z80fi_mem_wdata(z80fi_mem_wdata),
        .z80fi_mem_addr2(z80fi_mem_addr2), .z80fi_mem_rdata2(z80fi_mem_rdata2),
        .z80fi_reg_wr(z80fi_reg_wr), .z80fi_reg_wnum(z80fi_reg_wnum), .z80fi_reg_wdata(z80fi_reg_wdata),
        .z80fi_overflow(z80fi_overflow)
    );

    task automatic clear_ev();
        ev_start = 0; ev_fetch = 0; ev_reg_rd = 0; ev_mem_rd = 0; ev_mem_wr = 0;
        ev_reg_wr = 0; ev_retire = 0;
        ev_pc = 0; ev_reg_rdata = 0; ev_mem_addr = 0; ev_reg_wdata = 0; ev_pc_wdata = 0;
        ev_fetch_byte = 0; ev_mem_data = 0; ev_reg_rnum = 0; ev_reg_wnum = 0;
    endtask

    // Inputs set before the call are captured at the next rising edge;
    // on return they are cleared and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        clear_ev();
    endtask

    task automatic test_reset();
        clear_ev();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", z80fi_valid); end
        checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL reset_insn got %h exp 0", z80fi_insn); end
        checks++; if (z80fi_insn_len !== 3'd0) begin errors++; $display("FAIL reset_len got %h exp 0", z80fi_insn_len); end
        checks++; if (z80fi_pc_rdata !== 16'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", z80fi_pc_rdata); end
        checks++; if (z80fi_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %h exp 0", z80fi_overflow); end
        reset_n = 1;
        step();
    endtask

    task automatic test_ld_hl_n();
        ev_start = 1; ev_pc = 16'h0100; ev_fetch = 1; ev_fetch_byte = 8'h36; step();
        ev_fetch = 1; ev_fetch_byte = 8'h5A; step();
        ev_reg_rd = 1; ev_reg_rnum = 4'd6; ev_reg_rdata = 16'h8000; step();
        ev_mem_wr = 1; ev_mem_addr = 16'h8000; ev_mem_data = 8'h5A; step();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL ld_early_valid got %h exp 0", z80fi_valid); end
        ev_retire = 1; ev_pc_wdata = 16'h0102; step();
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ld_valid got %h exp 1", z80fi_valid); end
        checks++; if (z80fi_insn !== 32'h00005A36) begin errors++; $display("FAIL ld_insn got %h exp 00005a36", z80fi_insn); end
        checks++; if (z80fi_insn_len !== 3'd2) begin errors++; $display("FAIL ld_len got %h exp 2", z80fi_insn_len); end
        checks++; if (z80fi_pc_rdata !== 16'h0100) begin errors++; $display("FAIL ld_pc_rdata got %h exp 0100", z80fi_pc_rdata); end
        checks++; if (z80fi_pc_wdata !== 16'h0102) begin errors++; $display("FAIL ld_pc_wdata got %h exp 0102", z80fi_pc_wdata); end
        checks++; if (z80fi_mem_wr !== 1'b1) begin errors++; $display("FAIL ld_mem_wr got %h exp 1", z80fi_mem_wr); end
        checks++; if (z80fi_mem_addr !== 16'h8000) begin errors++; $display("FAIL ld_mem_addr got %h exp 8000", z80fi_mem_addr); end
        checks++; if (z80fi_mem_wdata !== 8'h5A) begin errors++; $display("FAIL ld_mem_wdata got %h exp 5a", z80fi_mem_wdata); end
        checks++; if (z80fi_reg1_rd !== 1'b1 || z80fi_reg1_rdata !== 16'h8000) begin errors++; $display("FAIL ld_reg1 got %h/%h exp 1/8000", z80fi_reg1_rd, z80fi_reg1_rdata); end
        checks++; if (z80fi_reg2_rd !== 1'b0) begin errors++; $display("FAIL ld_reg2_rd got %h exp 0", z80fi_reg2_rd); end
        checks++; if (z80fi_overflow !== 1'b0) begin errors++; $display("FAIL ld_ovf got %h exp 0", z80fi_overflow); end
        step();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL ld_valid_pulse got %h exp 0", z80fi_valid); end
    endtask

    task automatic test_back_to_back();
        ev_start = 1; ev_pc = 16'h0000; ev_fetch = 1; step();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_valid got %h exp 0", z80fi_valid); end
        for (int i = 0; i < 3; i++) begin
            ev_retire = 1; ev_pc_wdata = 16'(i + 1);
            if (i < 2) begin ev_start = 1; ev_pc = 16'(i + 1); ev_fetch = 1; end
            step();
            checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %h exp 1", i, z80fi_valid); end
            checks++; if (z80fi_pc_rdata !== 16'(i)) begin errors++; $display("FAIL b2b_pc_rdata[%0d] got %h exp %h", i, z80fi_pc_rdata, 16'(i)); end
            checks++; if (z80fi_pc_wdata !== 16'(i + 1)) begin errors++; $display("FAIL b2b_pc_wdata[%0d] got %h exp %h", i, z80fi_pc_wdata, 16'(i + 1)); end
            checks++; if (z80fi_insn_len !== 3'd1 || z80fi_overflow !== 1'b0) begin errors++; $display("FAIL b2b_len_ovf[%0d] got %h/%h exp 1/0", i, z80fi_insn_len, z80fi_overflow); end
        end
        step();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid got %h exp 0", z80fi_valid); end
    endtask

    task automatic test_fetch_overflow();
        logic [7:0] bytes [5];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        ev_start = 1; ev_pc = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            ev_fetch = 1; ev_fetch_byte = bytes[i];
            if (i == 4) begin ev_retire = 1; ev_pc_wdata = 16'h0205; end
            step();
        end
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL fovf_valid got %h exp 1", z80fi_valid); end
        checks++; if (z80fi_insn_len !== 3'd4) begin errors++; $display("FAIL fovf_len got %h exp 4", z80fi_insn_len); end
        checks++; if (z80fi_insn !== 32'h44332211) begin errors++; $display("FAIL fovf_insn got %h exp 44332211", z80fi_insn); end
        checks++; if (z80fi_overflow !== 1'b1) begin errors++; $display("FAIL fovf_ovf got %h exp 1", z80fi_overflow); end
        step();
    endtask

    task automatic test_reg_overflow();
        ev_start = 1; ev_pc = 16'h0300; ev_fetch = 1; ev_fetch_byte = 8'hED; step();
        ev_reg_rd = 1; ev_reg_rnum = 4'd1; ev_reg_rdata = 16'h1234; step();
        ev_reg_rd = 1; ev_reg_rnum = 4'd2; ev_reg_rdata = 16'h5678; step();
        ev_reg_rd = 1; ev_reg_rnum = 4'd3; ev_reg_rdata = 16'h9ABC; step();
        ev_retire = 1; ev_pc_wdata = 16'h0301; step();
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL rovf_valid got %h exp 1", z80fi_valid); end
        checks++; if (z80fi_reg1_rnum !== 4'd1 || z80fi_reg1_rdata !== 16'h1234) begin errors++; $display("FAIL rovf_reg1 got %h/%h exp 1/1234", z80fi_reg1_rnum, z80fi_reg1_rdata); end
        checks++; if (z80fi_reg2_rd !== 1'b1 || z80fi_reg2_rnum !== 4'd2 || z80fi_reg2_rdata !== 16'h5678) begin errors++; $display("FAIL rovf_reg2 got %h/%h/%h exp 1/2/5678", z80fi_reg2_rd, z80fi_reg2_rnum, z80fi_reg2_rdata); end
        checks++; if (z80fi_overflow !== 1'b1) begin errors++; $display("FAIL rovf_ovf got %h exp 1", z80fi_overflow); end
        step();
    endtask

    task automatic test_mem_and_regwr();
        ev_start = 1; ev_pc = 16'h0400; ev_fetch = 1; ev_fetch_byte = 8'h7E; step();
        ev_mem_rd = 1; ev_mem_addr = 16'h0010; ev_mem_data = 8'hAA; ev_reg_wr = 1; ev_reg_wnum = 4'd5; ev_reg_wdata = 16'h1111; step();
        ev_mem_rd = 1; ev_mem_addr = 16'h0011; ev_mem_data = 8'hBB; ev_reg_wr = 1; ev_reg_wnum = 4'd5; ev_reg_wdata = 16'h2222;
        ev_retire = 1; ev_pc_wdata = 16'h0401; step();
        checks++; if (z80fi_mem_rd !== 1'b1 || z80fi_mem_addr !== 16'h0010 || z80fi_mem_rdata !== 8'hAA) begin errors++; $display("FAIL mem_rd1 got %h/%h/%h exp 1/0010/aa", z80fi_mem_rd, z80fi_mem_addr, z80fi_mem_rdata); end
        checks++; if (z80fi_mem_rd2 !== 1'b1 || z80fi_mem_addr2 !== 16'h0011 || z80fi_mem_rdata2 !== 8'hBB) begin errors++; $display("FAIL mem_rd2 got %h/%h/%h exp 1/0011/bb", z80fi_mem_rd2, z80fi_mem_addr2, z80fi_mem_rdata2); end
        checks++; if (z80fi_reg_wr !== 1'b1 || z80fi_reg_wdata !== 16'h2222) begin errors++; $display("FAIL regwr_last got %h/%h exp 1/2222", z80fi_reg_wr, z80fi_reg_wdata); end
        checks++; if (z80fi_overflow !== 1'b0 || z80fi_mem_wr !== 1'b0) begin errors++; $display("FAIL mem_ovf_wr got %h/%h exp 0/0", z80fi_overflow, z80fi_mem_wr); end
        step();
        // Read plus write collide in the shared address slot.
        ev_start = 1; ev_pc = 16'h0500; ev_fetch = 1; ev_fetch_byte = 8'h34; step();
        ev_mem_rd = 1; ev_mem_addr = 16'h0020; ev_mem_data = 8'hCC; step();
        ev_mem_wr = 1; ev_mem_addr = 16'h0020; ev_mem_data = 8'hCD; ev_retire = 1; ev_pc_wdata = 16'h0501; step();
        checks++; if (z80fi_mem_rd !== 1'b1 || z80fi_mem_wr !== 1'b1 || z80fi_mem_wdata !== 8'hCD) begin errors++; $display("FAIL rdwr_flags got %h/%h/%h exp 1/1/cd", z80fi_mem_rd, z80fi_mem_wr, z80fi_mem_wdata); end
        checks++; if (z80fi_overflow !== 1'b1) begin errors++; $display("FAIL rdwr_ovf got %h exp 1", z80fi_overflow); end
        step();
    endtask

    task automatic test_len0_retire();
        ev_start = 1; ev_pc = 16'h0700; step();
        ev_retire = 1; ev_pc_wdata = 16'h0700; step();
        checks++; if (z80fi_valid !== 1'b1 || z80fi_insn_len !== 3'd0) begin errors++; $display("FAIL len0_valid_len got %h/%h exp 1/0", z80fi_valid, z80fi_insn_len); end
        checks++; if (z80fi_overflow !== 1'b1) begin errors++; $display("FAIL len0_ovf got %h exp 1", z80fi_overflow); end
        step();
    endtask

    task automatic test_reset_mid();
        ev_start = 1; ev_pc = 16'h0800; ev_fetch = 1; ev_fetch_byte = 8'h3E; step();
        reset_n = 0;
        #2;
        checks++; if (z80fi_insn !== 32'h0 || z80fi_insn_len !== 3'd0 || z80fi_pc_rdata !== 16'h0 || z80fi_overflow !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got %h/%h/%h/%h exp 0/0/0/0", z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_overflow); end
        reset_n = 1;
        ev_retire = 1; ev_pc_wdata = 16'h0802; step();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %h exp 0", z80fi_valid); end
        step();
        checks++; if (z80fi_valid !== 1'b0 || z80fi_insn !== 32'h0 || z80fi_pc_wdata !== 16'h0) begin errors++; $display("FAIL rstmid_after got %h/%h/%h exp 0/0/0", z80fi_valid, z80fi_insn, z80fi_pc_wdata); end
    endtask

    task automatic test_double_start();
        ev_start = 1; ev_pc = 16'h0900; ev_fetch = 1; ev_fetch_byte = 8'h01; step();
        ev_start = 1; ev_pc = 16'h0A00; ev_fetch = 1; ev_fetch_byte = 8'h00; step();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL dstart_no_pkt got %h exp 0", z80fi_valid); end
        ev_retire = 1; ev_pc_wdata = 16'h0A01; step();
        checks++; if (z80fi_valid !== 1'b1 || z80fi_pc_rdata !== 16'h0A00) begin errors++; $display("FAIL dstart_pkt got %h/%h exp 1/0a00", z80fi_valid, z80fi_pc_rdata); end
        checks++; if (z80fi_insn !== 32'h0 || z80fi_insn_len !== 3'd1) begin errors++; $display("FAIL dstart_insn got %h/%h exp 0/1", z80fi_insn, z80fi_insn_len); end
        checks++; if (z80fi_overflow !== 1'b1) begin errors++; $display("FAIL dstart_ovf got %h exp 1", z80fi_overflow); end
        step();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL dstart_tail got %h exp 0", z80fi_valid); end
    endtask

    initial begin
        test_reset();
        test_ld_hl_n();
        test_back_to_back();
        test_fetch_overflow();
        test_reg_overflow();
        test_mem_and_regwr();
        test_len0_retire();
        test_reset_mid();
        test_double_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
